// File: rtl/imm_decode_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | rv_decode_pkg : opcodes, immediate formats and FIFO entry layout for the |
// |                 RV32I immediate decode front-end                         |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_I       = 3'd1,
        FMT_SHAMT   = 3'd2,
        FMT_S       = 3'd3,
        FMT_B       = 3'd4,
        FMT_U       = 3'd5,
        FMT_J       = 3'd6,
        FMT_ILLEGAL = 3'd7
    } imm_fmt_e;

    // Bit positions of the generator select lines inside gen_sel
    localparam int SEL_TYPE  = 0;
    localparam int SEL_TYPE2 = 1;
    localparam int SEL_TYPE3 = 2;

    typedef struct packed {
        logic [31:0] imm;
        imm_fmt_e    fmt;
        logic        illegal;
        logic [19:0] gen_field;
        logic [2:0]  gen_sel;
    } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_decode_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | imm_decode_ctrl_if : instruction-in / decoded-immediate-out bus          |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

interface imm_decode_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [19:0] out_gen_field;
    logic        out_gen_type;
    logic        out_gen_type2;
    logic        out_gen_type3;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal,
               out_gen_field, out_gen_type, out_gen_type2, out_gen_type3
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal,
               out_gen_field, out_gen_type, out_gen_type2, out_gen_type3
    );

endinterface

`default_nettype wire

// File: rtl/imm_decode_ctrl_format_decode.sv
// +--------------------------------------------------------------------------+
// | imm_format_decode : combinational opcode classifier and immediate        |
// |                     builder producing one FIFO entry per instruction     |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_format_decode
    import rv_decode_pkg::*;
(
    input  wire logic [31:0] i_inst,
    output fifo_entry_t      o_entry
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [11:0] w_s_imm;
    logic [11:0] w_b_imm;
    logic [19:0] w_j_imm;
    imm_fmt_e    w_fmt;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_s_imm = {i_inst[31:25], i_inst[11:7]};
    assign w_b_imm = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8]};
    assign w_j_imm = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21]};

    // Every listed opcode ends in 2'b11, so compressed encodings fall to default
    always_comb begin
        w_fmt = FMT_ILLEGAL;
        case (w_opc)
            OPC_LOAD, OPC_FENCE, OPC_SYSTEM: w_fmt = FMT_I;
            OPC_JALR: begin
                if (w_f3 == 3'b000) w_fmt = FMT_I;
            end
            OPC_OP_IMM: begin
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && w_f3 == 3'b101))
                        w_fmt = FMT_SHAMT;
                end else begin
                    w_fmt = FMT_I;
                end
            end
            OPC_STORE: w_fmt = FMT_S;
            OPC_BRANCH: begin
                if (w_f3 != 3'b010 && w_f3 != 3'b011) w_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
            OPC_JAL:            w_fmt = FMT_J;
            OPC_OP:             w_fmt = FMT_NONE;
            default:            w_fmt = FMT_ILLEGAL;
        endcase
    end

    always_comb begin
        o_entry     = '0;
        o_entry.fmt = w_fmt;
        case (w_fmt)
            FMT_I: begin
                o_entry.gen_field = {8'b0, i_inst[31:20]};
                o_entry.imm       = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            FMT_SHAMT: begin
                o_entry.gen_field          = {15'b0, i_inst[24:20]};
                o_entry.gen_sel[SEL_TYPE]  = 1'b1;
                o_entry.imm                = {27'b0, i_inst[24:20]};
            end
            FMT_S: begin
                o_entry.gen_field = {8'b0, w_s_imm};
                o_entry.imm       = {{20{w_s_imm[11]}}, w_s_imm};
            end
            FMT_B: begin
                o_entry.gen_field          = {8'b0, w_b_imm};
                o_entry.gen_sel[SEL_TYPE2] = 1'b1;
                o_entry.imm                = {{19{w_b_imm[11]}}, w_b_imm, 1'b0};
            end
            FMT_U: begin
                o_entry.gen_field          = i_inst[31:12];
                o_entry.gen_sel[SEL_TYPE3] = 1'b1;
                o_entry.imm                = {i_inst[31:12], 12'b0};
            end
            FMT_J: begin
                o_entry.gen_field          = w_j_imm;
                o_entry.gen_sel[SEL_TYPE2] = 1'b1;
                o_entry.gen_sel[SEL_TYPE]  = 1'b1;
                o_entry.imm                = {{11{w_j_imm[19]}}, w_j_imm, 1'b0};
            end
            FMT_ILLEGAL: o_entry.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_decode_ctrl.sv
// +--------------------------------------------------------------------------+
// | imm_decode_ctrl : decode front-end with 2-entry output FIFO, valid/ready |
// |                   handshake and saturating illegal-instruction counter   |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_decode_ctrl
    import rv_decode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             flush,
    imm_decode_ctrl_if.slave      bus,
    output logic [CNT_W-1:0]      illegal_cnt
);

    fifo_entry_t      r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_illegal_cnt;

    fifo_entry_t      w_dec_entry;
    fifo_entry_t      w_head;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;

    imm_format_decode u_decode (
        .i_inst  (bus.in_inst),
        .o_entry (w_dec_entry)
    );

    // Ready depends only on registered occupancy so it never combinationally follows out_ready
    assign w_in_ready  = (r_count != 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts every accepted illegal instruction, including one discarded by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_push && w_dec_entry.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_imm       = w_head.imm;
    assign bus.out_fmt       = w_head.fmt;
    assign bus.out_illegal   = w_head.illegal;
    assign bus.out_gen_field = w_head.gen_field;
    assign bus.out_gen_type  = w_head.gen_sel[SEL_TYPE];
    assign bus.out_gen_type2 = w_head.gen_sel[SEL_TYPE2];
    assign bus.out_gen_type3 = w_head.gen_sel[SEL_TYPE3];
    assign illegal_cnt       = r_illegal_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_imm_decode_ctrl : directed stimulus against a queue-based reference   |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imm_decode_ctrl;

    localparam int TB_CNT_W = 3;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic [TB_CNT_W-1:0] illegal_cnt;

    imm_decode_ctrl_if bus_if ();

    imm_decode_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus_if),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [19:0] field;
        logic [2:0]  sel;   // {type3, type2, type}
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_en   = 1'b0;
    exp_t q[$];
    int   mcnt     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: classify by instruction class, then build the immediate with signed shifts
    function automatic exp_t model(input logic [31:0] x);
        exp_t               e;
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [31:0] t;
        opc = x[6:0];
        f3  = x[14:12];
        f7  = x[31:25];
        e   = '{imm: 32'h0, fmt: 3'd7, ill: 1'b0, field: 20'h0, sel: 3'b000};
        if (opc == 7'h03 || opc == 7'h0F || opc == 7'h73 || (opc == 7'h67 && f3 == 3'd0) ||
            (opc == 7'h13 && f3 != 3'd1 && f3 != 3'd5))
            e.fmt = 3'd1;
        else if (opc == 7'h13 && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)))
            e.fmt = 3'd2;
        else if (opc == 7'h23)                              e.fmt = 3'd3;
        else if (opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3) e.fmt = 3'd4;
        else if (opc == 7'h37 || opc == 7'h17)              e.fmt = 3'd5;
        else if (opc == 7'h6F)                              e.fmt = 3'd6;
        else if (opc == 7'h33)                              e.fmt = 3'd0;
        case (e.fmt)
            3'd1: begin t = x; e.imm = t >>> 20; e.field = {8'h0, x[31:20]}; end
            3'd2: begin e.imm = 32'(x[24:20]); e.field = 20'(x[24:20]); e.sel = 3'b001; end
            3'd3: begin
                e.field = {8'h0, x[31:25], x[11:7]};
                t = {e.field[11:0], 20'h0}; e.imm = t >>> 20;
            end
            3'd4: begin
                e.field = {8'h0, x[31], x[7], x[30:25], x[11:8]};
                t = {e.field[11:0], 20'h0}; e.imm = t >>> 19; e.sel = 3'b010;
            end
            3'd5: begin e.field = x[31:12]; e.imm = x & 32'hFFFF_F000; e.sel = 3'b100; end
            3'd6: begin
                e.field = {x[31], x[19:12], x[20], x[30:21]};
                t = {e.field, 12'h0}; e.imm = t >>> 11; e.sel = 3'b011;
            end
            3'd7: e.ill = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
        end else begin
            bit   acc, pop;
            exp_t e;
            acc = bus_if.in_valid && (q.size() < 2);
            pop = (q.size() > 0) && bus_if.out_ready;
            e   = model(bus_if.in_inst);
            if (acc && e.ill && mcnt < CNT_MAX) mcnt++;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_t h;
            h = (q.size() > 0) ? q[0] : '{imm: 32'h0, fmt: 3'd0, ill: 1'b0, field: 20'h0, sel: 3'b000};
            chk("in_ready",  32'(bus_if.in_ready),  32'(q.size() < 2));
            chk("out_valid", 32'(bus_if.out_valid), 32'(q.size() > 0));
            chk("imm",       bus_if.out_imm,        h.imm);
            chk("fmt",       32'(bus_if.out_fmt),   32'(h.fmt));
            chk("illegal",   32'(bus_if.out_illegal), 32'(h.ill));
            chk("field",     32'(bus_if.out_gen_field), 32'(h.field));
            chk("sel", 32'({bus_if.out_gen_type3, bus_if.out_gen_type2, bus_if.out_gen_type}), 32'(h.sel));
            chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
        end
    end

    task automatic head_is(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic [19:0] field, input logic [2:0] sel);
        chk({name, ".valid"}, 32'(bus_if.out_valid), 32'd1);
        chk({name, ".imm"},   bus_if.out_imm, imm);
        chk({name, ".fmt"},   32'(bus_if.out_fmt), 32'(fmt));
        chk({name, ".field"}, 32'(bus_if.out_gen_field), 32'(field));
        chk({name, ".sel"},
            32'({bus_if.out_gen_type3, bus_if.out_gen_type2, bus_if.out_gen_type}), 32'(sel));
    endtask

    // Send one instruction into an empty FIFO with out_ready high; check it one cycle later
    task automatic single(input string name, input logic [31:0] inst, input logic [31:0] imm,
                          input logic [2:0] fmt, input logic [19:0] field, input logic [2:0] sel);
        @(negedge clk); #1;
        bus_if.in_valid  = 1'b1;
        bus_if.in_inst   = inst;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        head_is(name, imm, fmt, field, sel);
        #1 bus_if.in_valid = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst);
        @(negedge clk); #1;
        bus_if.in_valid = v;
        bus_if.in_inst  = inst;
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_inst   = 32'h0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst.in_ready",  32'(bus_if.in_ready),  32'd1);
        chk("rst.cnt",       32'(illegal_cnt),      32'd0);
        chk("rst.imm",       bus_if.out_imm,        32'd0);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        single("addi",  32'hFFF00093, 32'hFFFF_FFFF, 3'd1, 20'h00FFF, 3'b000);
        single("srai",  32'h41F0D093, 32'h0000_001F, 3'd2, 20'h0001F, 3'b001);
        single("srai7", 32'hFFF0D093, 32'h0000_0000, 3'd7, 20'h00000, 3'b000);
        chk("srai7.cnt", 32'(illegal_cnt), 32'd1);
        single("beq",   32'hFE000EE3, 32'hFFFF_FFFC, 3'd4, 20'h00FFE, 3'b010);
        single("lui",   32'h123450B7, 32'h1234_5000, 3'd5, 20'h12345, 3'b100);
        single("sw",    32'hFE20AC23, 32'hFFFF_FFF8, 3'd3, 20'h00FF8, 3'b000);
        single("jal",   32'hFF9FF06F, 32'hFFFF_FFF8, 3'd6, 20'hFFFFC, 3'b011);
        single("add",   32'h002081B3, 32'h0000_0000, 3'd0, 20'h00000, 3'b000);
        single("jalr3", 32'h000030E7, 32'h0000_0000, 3'd7, 20'h00000, 3'b000);
        single("blt_ok",32'hFE004EE3, 32'hFFFF_FFFC, 3'd4, 20'h00FFE, 3'b010);

        // Backpressure: A and B fill the FIFO, C waits
        @(negedge clk); #1 bus_if.out_ready = 1'b0;
        drive(1'b1, 32'h00100093);
        drive(1'b1, 32'h00200093);
        drive(1'b1, 32'h00300093);
        @(negedge clk);
        chk("bp.in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("bp.A", bus_if.out_imm, 32'd1);
        #1 bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.B", bus_if.out_imm, 32'd2);
        @(negedge clk);
        chk("bp.C", bus_if.out_imm, 32'd3);
        #1 bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("bp.drained", 32'(bus_if.out_valid), 32'd0);

        // Asynchronous reset with one entry held
        #1 bus_if.out_ready = 1'b0;
        drive(1'b1, 32'h00100093);
        drive(1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("arst.cnt",       32'(illegal_cnt),      32'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // Flush at count=2 with a new instruction offered
        drive(1'b1, 32'h0000_0000);
        drive(1'b1, 32'h0000_0000);
        drive(1'b1, 32'h00100093);
        flush = 1'b1;
        @(negedge clk);
        chk("flush.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("flush.cnt",       32'(illegal_cnt),      32'd2);
        #1 flush = 1'b0;
        bus_if.in_inst = 32'h0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_acc.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("flush_acc.cnt",       32'(illegal_cnt),      32'd3);
        #1 flush = 1'b0;

        // Saturation of the illegal counter
        bus_if.out_ready = 1'b1;
        repeat (8) drive(1'b1, 32'h0000_0000);
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("sat.cnt", 32'(illegal_cnt), 32'(CNT_MAX));
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
